paralelo_serie_tx: RTL

PARALELO_SERIE_TX -- requirements
Module: paralelo_serie_tx

---
 rtl/paralelo_serie_tx.sv | 109 ++++++++++
 1 files changed

// File: rtl/paralelo_serie_tx.sv
// Parallel-to-serial lane transmitter: 2-entry byte FIFO feeding an 8-bit MSB-first
// serializer that fills idle slots with COM_SYM and runs a COM sync burst after reset.
module paralelo_serie_tx #(
  parameter int          SYNC_COUNT = 4,
  parameter logic [7:0]  COM_SYM    = 8'hBC
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       active_out,
  output logic       sym_is_data
);

  typedef enum logic {ST_SYNC = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [2:0] SYNC_LIM = 3'(SYNC_COUNT);

  state_t     state_r;
  logic [2:0] bit_cnt_r;
  logic [2:0] sync_cnt_r;
  logic [7:0] shift_r;
  logic [7:0] fifo0_r;
  logic [7:0] fifo1_r;
  logic [1:0] count_r;

  logic       push_s;
  logic       pop_s;
  logic       load_s;
  logic [7:0] sym_s;

  // Handshake, symbol-load strobe and symbol selection
  always_comb begin
    ready_out = (count_r < 2'd2);
    push_s    = valid_in && ready_out;
    load_s    = (bit_cnt_r == 3'd0);
    pop_s     = load_s && (state_r == ST_RUN) && (count_r != 2'd0);
    sym_s     = pop_s ? fifo0_r : COM_SYM;
  end

  // Serializer, sync state machine and FIFO storage
  always_ff @(posedge clk_8f) begin
    if (reset) begin
      state_r     <= ST_SYNC;
      bit_cnt_r   <= 3'd0;
      sync_cnt_r  <= 3'd0;
      shift_r     <= 8'd0;
      fifo0_r     <= 8'd0;
      fifo1_r     <= 8'd0;
      count_r     <= 2'd0;
      data_out    <= 1'b0;
      active_out  <= 1'b0;
      sym_is_data <= 1'b0;
    end else begin
      bit_cnt_r <= bit_cnt_r + 3'd1;

      if (load_s) begin
        shift_r     <= sym_s;
        data_out    <= sym_s[7];
        sym_is_data <= pop_s;
        // The comparison uses the pre-load count, so RUN begins with load SYNC_COUNT+1
        if (state_r == ST_SYNC) begin
          sync_cnt_r <= sync_cnt_r + 3'd1;
          if (sync_cnt_r == SYNC_LIM) begin
            state_r    <= ST_RUN;
            active_out <= 1'b1;
          end else begin
            state_r    <= ST_SYNC;
            active_out <= 1'b0;
          end
        end else begin
          state_r    <= ST_RUN;
          active_out <= 1'b1;
        end
      end else begin
        data_out <= shift_r[3'd7 - bit_cnt_r];
      end

      case ({push_s, pop_s})
        2'b11: begin
          if (count_r == 2'd1) begin
            fifo0_r <= data_in;
          end else begin
            fifo0_r <= fifo1_r;
            fifo1_r <= data_in;
          end
        end
        2'b10: begin
          if (count_r == 2'd0) begin
            fifo0_r <= data_in;
          end else begin
            fifo1_r <= data_in;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          fifo0_r <= fifo1_r;
          count_r <= count_r - 2'd1;
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

endmodule
